// File: rtl/matrix_scan_controller.sv
// Time-multiplexed row scanner for a ROWS x COLS LED matrix with a tear-free shadow frame buffer.
// Optional per-frame PWM brightness is enabled by defining MATRIX_SCAN_PWM_EN.
module matrix_scan_controller #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 12,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned BLANK_CYCLES = 1
`ifdef MATRIX_SCAN_PWM_EN
    ,
    parameter int unsigned PWM_BITS     = 4
`endif
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [ROWS*COLS-1:0]   frame,
    input  logic                   frame_valid,
`ifdef MATRIX_SCAN_PWM_EN
    input  logic [PWM_BITS-1:0]    brightness,
`endif
    output logic                   frame_ready,
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        col_data,
    output logic                   frame_start,
    output logic                   scanning
);

    localparam int unsigned FRAME_W = ROWS * COLS;
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;
    // With no blanking, a row hands straight over to the next row's drive phase.
    localparam logic [1:0] ROW_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

`ifdef MATRIX_SCAN_PWM_EN
    localparam int unsigned CMP_W = (CNT_W > PWM_BITS) ? CNT_W : PWM_BITS;
    logic [PWM_BITS-1:0] bright_q, bright_d;
`endif

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_idx_q, row_idx_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               shadow_full_q, shadow_full_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [ROWS-1:0]    row_sel_q, row_sel_d;
    logic [COLS-1:0]    col_data_q, col_data_d;
    logic               frame_start_q, frame_start_d;
    logic               scanning_q, scanning_d;
    logic               commit;

    // Next-state, buffer handshake and registered output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_idx_d     = row_idx_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        commit        = 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
        bright_d      = bright_q;
`endif

        if (frame_valid && !shadow_full_q) begin
            shadow_d      = frame;
            shadow_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (shadow_full_q) begin
                    commit    = 1'b1;
                    row_idx_d = '0;
                    cnt_d     = '0;
                    state_d   = ROW_ENTRY;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = ROW_ENTRY;
                    if (row_idx_q == ROW_LAST) begin
                        row_idx_d = '0;
                        commit    = shadow_full_q;
                    end else begin
                        row_idx_d = row_idx_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                row_idx_d = '0;
            end
        endcase

        // Commit only fires with the shadow full, so it never collides with an accept.
        if (commit) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            frame_start_d = 1'b1;
`ifdef MATRIX_SCAN_PWM_EN
            bright_d      = brightness;
`endif
        end

        scanning_d = (state_d != IDLE);
        row_sel_d  = '0;
        col_data_d = '0;
        if (state_d == DRIVE) begin
            row_sel_d  = ROWS'(1) << row_idx_d;
            col_data_d = COLS'(active_d >> (32'(row_idx_d) * COLS));
`ifdef MATRIX_SCAN_PWM_EN
            if (CMP_W'(cnt_d) >= CMP_W'(bright_d)) begin
                col_data_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_idx_q     <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
            scanning_q    <= 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
            bright_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
            scanning_q    <= scanning_d;
`ifdef MATRIX_SCAN_PWM_EN
            bright_q      <= bright_d;
`endif
        end
    end

    assign frame_ready = !shadow_full_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_start = frame_start_q;
    assign scanning    = scanning_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Table-driven bench for matrix_scan_controller: default 8x12 instance plus a 4x4 no-blank instance.
// PWM checks are included when MATRIX_SCAN_PWM_EN is defined.
module tb_matrix_scan_controller;

    logic         clock;
    logic         resetn;
    logic [95:0]  frame;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   row_sel;
    logic [11:0]  col_data;
    logic         frame_start;
    logic         scanning;
`ifdef MATRIX_SCAN_PWM_EN
    logic [3:0]   brightness;
`endif

    logic         resetn2;
    logic [15:0]  frame2;
    logic         frame_valid2;
    logic         frame_ready2;
    logic [3:0]   row_sel2;
    logic [3:0]   col_data2;
    logic         frame_start2;
    logic         scanning2;

    matrix_scan_controller dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame       (frame),
        .frame_valid (frame_valid),
`ifdef MATRIX_SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start),
        .scanning    (scanning)
    );

    matrix_scan_controller #(
        .ROWS         (4),
        .COLS         (4),
        .DWELL_CYCLES (1),
        .BLANK_CYCLES (0)
    ) dut2 (
        .clock       (clock),
        .resetn      (resetn2),
        .frame       (frame2),
        .frame_valid (frame_valid2),
`ifdef MATRIX_SCAN_PWM_EN
        .brightness  (4'hF),
`endif
        .frame_ready (frame_ready2),
        .row_sel     (row_sel2),
        .col_data    (col_data2),
        .frame_start (frame_start2),
        .scanning    (scanning2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rn;
        bit          v;
        logic [95:0] f;
        logic [7:0]  rs;
        logic [11:0] cd;
        bit          fs;
        bit          sc;
        bit          rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [95:0] F1   = 96'h1;
    localparam logic [95:0] F2   = 96'hFFF << 84;
    localparam logic [95:0] F3   = 96'hABC << 36;
    localparam logic [95:0] F4   = 96'h2;
    localparam logic [95:0] ALL1 = {96{1'b1}};

    function automatic void add(bit rn, bit v, logic [95:0] f, logic [7:0] rs,
                                logic [11:0] cd, bit fs, bit sc, bit rdy);
        vec_t t;
        t.rn = rn; t.v = v; t.f = f; t.rs = rs; t.cd = cd; t.fs = fs; t.sc = sc; t.rdy = rdy;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack1(logic [7:0] rs, logic [11:0] cd, bit fs, bit sc, bit rdy);
        return {9'd0, rs, cd, fs, sc, rdy};
    endfunction

    // Expected scan output k cycles after a commit edge (1 blank + 4 dwell per row).
    function automatic void scan_exp(int k, logic [95:0] act, output logic [7:0] rs,
                                     output logic [11:0] cd);
        int phase;
        int r;
        phase = k % 5;
        r     = (k / 5) % 8;
        rs    = (phase == 0) ? 8'h00 : 8'(1 << r);
        cd    = (phase == 0) ? 12'h000 : act[r*12 +: 12];
    endfunction

    initial begin
        logic [7:0]  e_rs;
        logic [11:0] e_cd;
        logic [95:0] act;
        logic [95:0] fin;
        bit          v;
        bit          fs;
        bit          rdy;

        resetn       = 1'b0;
        frame        = '0;
        frame_valid  = 1'b0;
        resetn2      = 1'b0;
        frame2       = '0;
        frame_valid2 = 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
        brightness   = 4'hF;
`endif

        // Reset, idle, accept F1.
        add(0, 0, '0, 8'h00, 12'h000, 0, 0, 1);
        for (int i = 0; i < 20; i++) add(1, 0, '0, 8'h00, 12'h000, 0, 0, 1);
        add(1, 1, F1, 8'h00, 12'h000, 0, 0, 0);

        // Scan from commit of F1; F2 accepted mid-scan, F3 accepted on a commit point.
        for (int k = 0; k < 177; k++) begin
            act = (k < 80) ? F1 : ((k < 160) ? F2 : F3);
            scan_exp(k, act, e_rs, e_cd);
            v   = (k == 45) || (k == 50) || (k == 120) || (k == 172);
            fin = (k == 45) ? F2 : (k == 120) ? F3 : (v ? ALL1 : 96'h0);
            fs  = (k == 0) || (k == 80) || (k == 160);
            rdy = !((k >= 45 && k < 80) || (k >= 120 && k < 160) || (k >= 172));
            add(1, v, fin, e_rs, e_cd, fs, 1, rdy);
        end

        // Reset during row 3 drive discards the pending shadow frame.
        add(0, 0, '0, 8'h00, 12'h000, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(1, 0, '0, 8'h00, 12'h000, 0, 0, 1);
        add(1, 1, F4, 8'h00, 12'h000, 0, 0, 0);
        add(1, 0, '0, 8'h00, 12'h000, 1, 1, 1);
        add(1, 0, '0, 8'h01, 12'h002, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            resetn      = vecs[i].rn;
            frame_valid = vecs[i].v;
            frame       = vecs[i].f;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d rs/cd/fs/sc/rdy", i),
                  pack1(row_sel, col_data, frame_start, scanning, frame_ready),
                  pack1(vecs[i].rs, vecs[i].cd, vecs[i].fs, vecs[i].sc, vecs[i].rdy));
        end
        frame_valid = 1'b0;

        // 4x4, no blanking, single-cycle dwell: row_sel walks 1,2,4,8.
        resetn2 = 1'b0;
        @(posedge clock); #1;
        check("dut2 reset", {26'd0, row_sel2, frame_start2, scanning2, frame_ready2},
              {26'd0, 4'h0, 1'b0, 1'b0, 1'b1});
        resetn2      = 1'b1;
        frame_valid2 = 1'b1;
        frame2       = 16'h8421;
        @(posedge clock); #1;
        frame_valid2 = 1'b0;
        check("dut2 accept", {26'd0, row_sel2, frame_start2, scanning2, frame_ready2},
              {26'd0, 4'h0, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < 12; j++) begin
            @(posedge clock); #1;
            check($sformatf("dut2 walk%0d", j),
                  {22'd0, row_sel2, col_data2, frame_start2, scanning2, frame_ready2},
                  {22'd0, 4'(1 << (j % 4)), 4'(1 << (j % 4)), (j == 0), 1'b1, 1'b1});
        end

`ifdef MATRIX_SCAN_PWM_EN
        // Brightness 2 lights the first two dwell cycles; brightness 0 is dark.
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn      = 1'b1;
        brightness  = 4'd2;
        frame_valid = 1'b1;
        frame       = ALL1;
        @(posedge clock); #1;
        frame_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            frame_valid = (k == 10);
            if (k == 11) brightness = 4'd0;
            @(posedge clock); #1;
            scan_exp(k, ALL1, e_rs, e_cd);
            if (k >= 40 || (k % 5) > 2) e_cd = 12'h000;
            check($sformatf("pwm k%0d", k),
                  pack1(row_sel, col_data, frame_start, scanning, frame_ready),
                  pack1(e_rs, e_cd, (k == 0) || (k == 40), 1'b1, !(k >= 10 && k < 40)));
        end
        frame_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
